combo_lock_core: RTL and testbench

//  Moore-style combination-lock controller; consumes one-cycle pulses from the per-button input

---
 rtl/combo_lock_core_pkg.sv | 27 ++
 rtl/combo_lock_core_cycle_timer.sv | 30 +++
 rtl/combo_lock_core.sv | 159 +++++++++++++++
 tb/tb_combo_lock_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_core_pkg.sv
// Shared definitions for the combination-lock controller: state encodings
// and small elaboration-time helpers.
package combo_lock_core_pkg;

    localparam int STATE_W = 3;

    // Controller states (explicit encodings; anything else recovers to ENTRY)
    localparam logic [STATE_W-1:0] ST_ENTRY   = 3'd0;
    localparam logic [STATE_W-1:0] ST_VERDICT = 3'd1;
    localparam logic [STATE_W-1:0] ST_OPEN    = 3'd2;
    localparam logic [STATE_W-1:0] ST_FAIL    = 3'd3;
    localparam logic [STATE_W-1:0] ST_LOCKOUT = 3'd4;

    // Default geometry of a combination
    localparam int DEF_DIGIT_W  = 4;
    localparam int DEF_CODE_LEN = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold values 0..n-1 (at least one bit)
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/combo_lock_core_cycle_timer.sv
// Loadable down-counter used to time the OPEN and LOCKOUT dwell periods.
// done is high whenever the count reads zero; the count holds at zero.
module cycle_timer
    import combo_lock_core_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count_reg;

    // Load takes priority; otherwise count down and stop at zero
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/combo_lock_core.sv
// Moore combination-lock controller. Digits are compared one by one against
// a packed code; a wrong digit only sets a sticky mismatch flag so the user
// learns nothing until the full sequence has been entered.
module combo_lock_core
    import combo_lock_core_pkg::*;
#(
    parameter int                          CODE_LEN       = DEF_CODE_LEN,
    parameter int                          DIGIT_W        = DEF_DIGIT_W,
    parameter logic [CODE_LEN*DIGIT_W-1:0] CODE           = 16'h1234,
    parameter int                          MAX_FAILS      = 3,
    parameter int                          UNLOCK_CYCLES  = 8,
    parameter int                          LOCKOUT_CYCLES = 16,
    localparam int                         CNT_W          = $clog2(CODE_LEN + 1),
    localparam int                         FAIL_W         = $clog2(MAX_FAILS + 1)
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               enter_pulse,
    input  logic               clear_pulse,
    input  logic [DIGIT_W-1:0] digit,
    output logic               unlocked,
    output logic               error,
    output logic               locked_out,
    output logic [CNT_W-1:0]   digit_count,
    output logic [FAIL_W-1:0]  fail_count
);

    localparam int TIMER_W = count_width(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES));
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LAST_DIGIT   = CNT_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0]  FAIL_LIMIT   = FAIL_W'(MAX_FAILS);

    logic [STATE_W-1:0] state_reg, state_next;
    logic [CNT_W-1:0]   digit_count_reg, digit_count_next;
    logic               mismatch_reg, mismatch_next;
    logic [FAIL_W-1:0]  fail_count_reg, fail_count_next;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_done;

    logic [DIGIT_W-1:0] code_digits [CODE_LEN];
    logic [DIGIT_W-1:0] expected_digit;

    // Unpack the code; digit 0 lives in the most-significant slot
    generate
        for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_code
            assign code_digits[gi] = CODE[(CODE_LEN-1-gi)*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    // Select the code digit expected at the current entry position
    always_comb begin
        expected_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (digit_count_reg == CNT_W'(i)) begin
                expected_digit = code_digits[i];
            end
        end
    end

    cycle_timer #(
        .W(TIMER_W)
    ) u_timer (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // Next-state and datapath update; pulses are only honoured in ENTRY
    always_comb begin
        state_next       = state_reg;
        digit_count_next = digit_count_reg;
        mismatch_next    = mismatch_reg;
        fail_count_next  = fail_count_reg;
        timer_load       = 1'b0;
        timer_value      = '0;
        case (state_reg)
            ST_ENTRY: begin
                if (clear_pulse) begin
                    // clear beats a simultaneous enter; the digit is dropped
                    digit_count_next = '0;
                    mismatch_next    = 1'b0;
                end else if (enter_pulse) begin
                    mismatch_next    = mismatch_reg | (digit != expected_digit);
                    digit_count_next = digit_count_reg + 1'b1;
                    if (digit_count_reg == LAST_DIGIT) begin
                        state_next = ST_VERDICT;
                    end
                end
            end
            ST_VERDICT: begin
                digit_count_next = '0;
                mismatch_next    = 1'b0;
                if (!mismatch_reg) begin
                    state_next      = ST_OPEN;
                    fail_count_next = '0;
                    timer_load      = 1'b1;
                    timer_value     = UNLOCK_LOAD;
                end else begin
                    state_next = ST_FAIL;
                    if (fail_count_reg != FAIL_LIMIT) begin
                        fail_count_next = fail_count_reg + 1'b1;
                    end
                end
            end
            ST_OPEN: begin
                if (timer_done) begin
                    state_next = ST_ENTRY;
                end
            end
            ST_FAIL: begin
                if (fail_count_reg == FAIL_LIMIT) begin
                    state_next  = ST_LOCKOUT;
                    timer_load  = 1'b1;
                    timer_value = LOCKOUT_LOAD;
                end else begin
                    state_next = ST_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_next      = ST_ENTRY;
                    fail_count_next = '0;
                end
            end
            default: begin
                state_next       = ST_ENTRY;
                digit_count_next = '0;
                mismatch_next    = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous abort to the idle entry state
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg       <= ST_ENTRY;
            digit_count_reg <= '0;
            mismatch_reg    <= 1'b0;
            fail_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            digit_count_reg <= digit_count_next;
            mismatch_reg    <= mismatch_next;
            fail_count_reg  <= fail_count_next;
        end
    end

    assign unlocked    = (state_reg == ST_OPEN);
    assign error       = (state_reg == ST_FAIL);
    assign locked_out  = (state_reg == ST_LOCKOUT);
    assign digit_count = digit_count_reg;
    assign fail_count  = fail_count_reg;

endmodule

// File: tb/tb_combo_lock_core.sv
// Directed bench for combo_lock_core with the default code 1234: a vector
// table for entry/clear/open/fail basics plus hand sequences for lockout,
// recovery and asynchronous reset.
module tb_combo_lock_core;

    logic       Clock;
    logic       Resetn;
    logic       enter_pulse;
    logic       clear_pulse;
    logic [3:0] digit;
    logic       unlocked;
    logic       error;
    logic       locked_out;
    logic [2:0] digit_count;
    logic [1:0] fail_count;

    int total;
    int bad;

    typedef struct {
        logic       enter;
        logic       clear;
        logic [3:0] dig;
        logic       exp_unl;
        logic       exp_err;
        logic       exp_lko;
        logic [2:0] exp_dc;
        logic [1:0] exp_fc;
    } vec_t;

    vec_t vecs[$];

    combo_lock_core dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .enter_pulse (enter_pulse),
        .clear_pulse (clear_pulse),
        .digit       (digit),
        .unlocked    (unlocked),
        .error       (error),
        .locked_out  (locked_out),
        .digit_count (digit_count),
        .fail_count  (fail_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_all(input string name, input logic u, input logic e, input logic l,
                             input logic [2:0] dc, input logic [1:0] fc);
        check({name, ".unlocked"}, int'(unlocked), int'(u));
        check({name, ".error"}, int'(error), int'(e));
        check({name, ".locked_out"}, int'(locked_out), int'(l));
        check({name, ".digit_count"}, int'(digit_count), int'(dc));
        check({name, ".fail_count"}, int'(fail_count), int'(fc));
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the rising edge
    task automatic step(input logic e, input logic c, input logic [3:0] d);
        @(negedge Clock);
        enter_pulse = e;
        clear_pulse = c;
        digit       = d;
        @(posedge Clock);
        #1;
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
    endtask

    // Enter four digits; afterwards the core sits in VERDICT
    task automatic enter4(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3);
        step(1'b1, 1'b0, d0);
        step(1'b1, 1'b0, d1);
        step(1'b1, 1'b0, d2);
        step(1'b1, 1'b0, d3);
        check("seq.verdict_dc", int'(digit_count), 4);
        check("seq.verdict_no_early_err", int'(error), 0);
    endtask

    // Wrong code 1,2,9,4 then the FAIL cycle and the cycle after it
    task automatic wrong_seq(input int fc_after, input int tag);
        enter4(4'd1, 4'd2, 4'd9, 4'd4);
        step(1'b0, 1'b0, 4'd0);
        $display("wrong sequence %0d: error=%0d fail_count=%0d", tag, error, fail_count);
        check("wrong.error", int'(error), 1);
        check("wrong.fail_count", int'(fail_count), fc_after);
        check("wrong.unlocked", int'(unlocked), 0);
        step(1'b0, 1'b0, 4'd0);
        check("wrong.error_one_cycle", int'(error), 0);
        check("wrong.locked_out", int'(locked_out), (fc_after == 3) ? 1 : 0);
    endtask

    // Correct code, then 8 cycles unlocked, then back to ENTRY
    task automatic correct_seq(input int tag);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 4'd0);
            check("open.unlocked", int'(unlocked), 1);
            check("open.fail_count", int'(fail_count), 0);
            check("open.error", int'(error), 0);
        end
        $display("correct sequence %0d: open for 8 cycles", tag);
        step(1'b0, 1'b0, 4'd0);
        check("open.exit_unlocked", int'(unlocked), 0);
        check("open.exit_dc", int'(digit_count), 0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
        digit       = 4'd0;
        Resetn      = 1'b0;

        // enter, clear, dig, unl, err, lko, dc, fc
        vecs.push_back('{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0});
        vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0});
        vecs.push_back('{1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0});
        vecs.push_back('{1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 3'd4, 2'd0});
        for (int i = 0; i < 8; i++) begin
            // pulses during OPEN must be ignored
            vecs.push_back('{(i == 2), (i == 4), 4'd1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0});
        end
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 3'd4, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1});

        // Reset state, checked while reset is still asserted
        #12;
        check_all("reset", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        @(negedge Clock);
        Resetn = 1'b1;

        // Table: clear, clear+enter, correct open, ignored pulses, first fail
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].enter, vecs[i].clear, vecs[i].dig);
            $display("vec %0d: en=%0d clr=%0d d=%0d -> unl=%0d err=%0d lko=%0d dc=%0d fc=%0d",
                     i, vecs[i].enter, vecs[i].clear, vecs[i].dig,
                     unlocked, error, locked_out, digit_count, fail_count);
            check_all($sformatf("vec%0d", i), vecs[i].exp_unl, vecs[i].exp_err,
                      vecs[i].exp_lko, vecs[i].exp_dc, vecs[i].exp_fc);
        end

        // Lockout: two more failures on top of the one above
        wrong_seq(2, 2);
        enter4(4'd1, 4'd2, 4'd9, 4'd4);
        step(1'b1, 1'b0, 4'd1);
        check("third.error", int'(error), 1);
        check("third.fail_count", int'(fail_count), 3);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i == 5), 4'(i % 4 + 1));
            check("lockout.locked_out", int'(locked_out), 1);
            check("lockout.dc_ignored", int'(digit_count), 0);
            check("lockout.unlocked", int'(unlocked), 0);
        end
        step(1'b0, 1'b0, 4'd0);
        $display("lockout exit: locked_out=%0d fail_count=%0d", locked_out, fail_count);
        check("lockout.exit", int'(locked_out), 0);
        check("lockout.exit_fc", int'(fail_count), 0);
        correct_seq(1);

        // Recovery: two fails, a success clears the count, one fail is not a lockout
        wrong_seq(1, 10);
        wrong_seq(2, 11);
        correct_seq(2);
        wrong_seq(1, 12);

        // Async reset in the middle of OPEN
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        check("pre_rst.unlocked", int'(unlocked), 1);
        #2;
        Resetn = 1'b0;
        #1;
        $display("async reset in OPEN: unlocked=%0d fc=%0d", unlocked, fail_count);
        check_all("rst_open", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        @(negedge Clock);
        Resetn = 1'b1;

        // Async reset with three digits already accepted
        step(1'b1, 1'b0, 4'd1);
        step(1'b1, 1'b0, 4'd2);
        step(1'b1, 1'b0, 4'd3);
        check("pre_rst.dc", int'(digit_count), 3);
        #2;
        Resetn = 1'b0;
        #1;
        $display("async reset in ENTRY: dc=%0d", digit_count);
        check_all("rst_entry", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        correct_seq(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
